// File: rtl/dump_ctrl.sv
// dump_ctrl: streams one channel's circular capture RAM out over the UART,
// oldest sample first, one byte per transmitter handshake. An invalid
// channel request is answered with a single 8'hEE NACK byte.
//
// Handshake: a byte is offered by a one-cycle send_resp_o pulse, and
// resp_o carries that byte on the same cycle. resp_o and raddr_o stay
// stable until resp_sent_i is seen high on a rising edge while the FSM
// waits. resp_sent_i is ignored in every other state. start_i is only
// accepted while busy_o is low. busy_o rises with the accepted start and
// falls on the cycle after the dump_done_o pulse.
module dump_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      ch_sel_i,
  input  logic [LOG2-1:0] waddr_i,
  input  logic [7:0]      rdata_ch1_i,
  input  logic [7:0]      rdata_ch2_i,
  input  logic [7:0]      rdata_ch3_i,
  input  logic [7:0]      rdata_ch4_i,
  input  logic [7:0]      rdata_ch5_i,
  input  logic            resp_sent_i,
  output logic [LOG2-1:0] raddr_o,
  output logic [7:0]      resp_o,
  output logic            send_resp_o,
  output logic            busy_o,
  output logic            dump_done_o,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_NACK = 3'd4
  } state_t;

  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
  localparam logic [7:0]      NACK_BYTE = 8'hEE;

  state_t          state_q, state_d;
  logic [LOG2-1:0] raddr_q, raddr_d;
  logic [7:0]      resp_q, resp_d;
  logic            send_q, send_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2:0]      ch_q, ch_d;
  logic [LOG2-1:0] start_addr_q, start_addr_d;

  logic [LOG2-1:0] next_addr;
  logic [7:0]      rdata_sel;
  logic            ch_valid;

  // Circular successor of the current read address; wraps at the last entry.
  always_comb begin
    if (raddr_q == LAST_ADDR) begin
      next_addr = '0;
    end else begin
      next_addr = raddr_q + LOG2'(1);
    end
  end

  // Read data of the channel latched at the accepted start.
  always_comb begin
    rdata_sel = 8'h00;
    case (ch_q)
      3'd1:    rdata_sel = rdata_ch1_i;
      3'd2:    rdata_sel = rdata_ch2_i;
      3'd3:    rdata_sel = rdata_ch3_i;
      3'd4:    rdata_sel = rdata_ch4_i;
      3'd5:    rdata_sel = rdata_ch5_i;
      default: rdata_sel = 8'h00;
    endcase
  end

  // Only channels 1..5 exist.
  always_comb begin
    ch_valid = (ch_sel_i >= 3'd1) && (ch_sel_i <= 3'd5);
  end

  // Next-state and registered-output logic of the dump sequencer.
  always_comb begin
    state_d      = state_q;
    raddr_d      = raddr_q;
    resp_d       = resp_q;
    send_d       = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ch_d         = ch_q;
    start_addr_d = start_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (busy_q) begin
          // Cycle carrying dump_done: busy drops afterwards, start ignored.
          busy_d = 1'b0;
        end else if (start_i) begin
          busy_d = 1'b1;
          if (ch_valid) begin
            ch_d         = ch_sel_i;
            start_addr_d = waddr_i;
            raddr_d      = waddr_i;
            state_d      = ST_READ;
          end else begin
            resp_d  = NACK_BYTE;
            send_d  = 1'b1;
            state_d = ST_NACK;
          end
        end
      end
      ST_READ: begin
        // RAM read latency slot.
        state_d = ST_SEND;
      end
      ST_SEND: begin
        resp_d  = rdata_sel;
        send_d  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (resp_sent_i) begin
          if (next_addr == start_addr_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            raddr_d = next_addr;
            state_d = ST_READ;
          end
        end
      end
      ST_NACK: begin
        if (resp_sent_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      raddr_q      <= '0;
      resp_q       <= 8'h00;
      send_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ch_q         <= 3'd0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      raddr_q      <= raddr_d;
      resp_q       <= resp_d;
      send_q       <= send_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ch_q         <= ch_d;
      start_addr_q <= start_addr_d;
    end
  end

  assign raddr_o     = raddr_q;
  assign resp_o      = resp_q;
  assign send_resp_o = send_q;
  assign busy_o      = busy_q;
  assign dump_done_o = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dump_ctrl.sv
// tb_dump_ctrl: directed bench for dump_ctrl with a registered RAM model,
// an expected byte/address queue and a final error report.
module tb_dump_ctrl;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_NACK = 3'd4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [2:0]      ch_sel;
  logic [LOG2-1:0] waddr;
  logic [7:0]      rdata1, rdata2, rdata3, rdata4, rdata5;
  logic            resp_sent;
  logic [LOG2-1:0] raddr;
  logic [7:0]      resp;
  logic            send_resp;
  logic            busy;
  logic            dump_done;
  logic [2:0]      dbg_state;

  int errors = 0;
  int checks = 0;
  int n_send = 0;
  int n_done = 0;

  logic [7:0]      exp_q[$];
  logic [LOG2-1:0] addr_q[$];

  dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .ch_sel_i    (ch_sel),
    .waddr_i     (waddr),
    .rdata_ch1_i (rdata1),
    .rdata_ch2_i (rdata2),
    .rdata_ch3_i (rdata3),
    .rdata_ch4_i (rdata4),
    .rdata_ch5_i (rdata5),
    .resp_sent_i (resp_sent),
    .raddr_o     (raddr),
    .resp_o      (resp),
    .send_resp_o (send_resp),
    .busy_o      (busy),
    .dump_done_o (dump_done),
    .dbg_state_o (dbg_state)
  );

  // Clock and RAM model: contents are a fixed function of channel and address.
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_val(input int ch, input int a);
    return 8'((a * 3 + ch * 41 + (a >> 8)) & 255);
  endfunction

  always @(posedge clk) begin
    rdata1 <= ram_val(1, int'(raddr));
    rdata2 <= ram_val(2, int'(raddr));
    rdata3 <= ram_val(3, int'(raddr));
    rdata4 <= ram_val(4, int'(raddr));
    rdata5 <= ram_val(5, int'(raddr));
  end

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (send_resp === 1'b1) n_send = n_send + 1;
    if (dump_done === 1'b1) n_done = n_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_exp(input int ch, input int sa);
    exp_q.delete();
    addr_q.delete();
    for (int k = 0; k < ENTRIES; k++) begin
      int a;
      a = (sa + k) % ENTRIES;
      addr_q.push_back(LOG2'(a));
      exp_q.push_back(ram_val(ch, a));
    end
  endtask

  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (send_resp === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Full dump with the UART answering 3 cycles after each send_resp.
  // With inject set, a start for channel 5 is pulsed and waddr wanders mid-dump.
  task automatic run_dump(input int ch, input int sa, input bit inject);
    bit ok;
    build_exp(ch, sa);
    n_send = 0;
    n_done = 0;
    @(negedge clk);
    start  = 1'b1;
    ch_sel = 3'(ch);
    waddr  = LOG2'(sa);
    @(negedge clk);
    start = 1'b0;
    check("busy_set", 32'(busy), 32'd1);
    check("raddr_load", 32'(raddr), 32'(sa));
    check("state_read", 32'(dbg_state), 32'(S_READ));
    for (int i = 0; i < ENTRIES; i++) begin
      wait_send(ok);
      if (!ok) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
      check("resp_byte", 32'(resp), 32'(exp_q.pop_front()));
      check("raddr_seq", 32'(raddr), 32'(addr_q.pop_front()));
      @(negedge clk);
      if (inject && i == 10) begin
        start  = 1'b1;
        ch_sel = 3'd5;
        waddr  = LOG2'(100);
      end
      @(negedge clk);
      start = 1'b0;
      if (inject) waddr = LOG2'((i * 7) % ENTRIES);
      @(negedge clk);
      resp_sent = 1'b1;
      @(negedge clk);
      resp_sent = 1'b0;
      if (i == ENTRIES - 1) begin
        check("done_pulse", 32'(dump_done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd1);
      end
    end
    @(negedge clk);
    check("done_cleared", 32'(dump_done), 32'd0);
    check("busy_cleared", 32'(busy), 32'd0);
    check("state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("byte_count", 32'(n_send), 32'(ENTRIES));
    check("done_count", 32'(n_done), 32'd1);
    check("exp_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int snap;
    rst_n     = 1'b0;
    start     = 1'b0;
    ch_sel    = 3'd0;
    waddr     = '0;
    resp_sent = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_resp", 32'(resp), 32'd0);
    check("rst_send", 32'(send_resp), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(dump_done), 32'd0);
    rst_n = 1'b1;

    // Normal, wrapping and disturbed dumps.
    run_dump(3, 5, 1'b0);
    run_dump(1, 383, 1'b0);
    run_dump(2, 200, 1'b1);

    // Stray resp_sent in IDLE.
    snap = n_send;
    @(negedge clk);
    resp_sent = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_stray_state", 32'(dbg_state), 32'(S_IDLE));
    check("idle_stray_busy", 32'(busy), 32'd0);
    check("idle_stray_send", 32'(n_send - snap), 32'd0);

    // Stray resp_sent in READ, then reset in the middle of the dump.
    start  = 1'b1;
    ch_sel = 3'd4;
    waddr  = LOG2'(0);
    @(negedge clk);
    start = 1'b0;
    check("stray_read_state", 32'(dbg_state), 32'(S_READ));
    @(negedge clk);
    check("stray_send_state", 32'(dbg_state), 32'(S_SEND));
    check("stray_no_send", 32'(send_resp), 32'd0);
    resp_sent = 1'b0;
    @(negedge clk);
    check("stray_wait_state", 32'(dbg_state), 32'(S_WAIT));
    check("stray_send_once", 32'(send_resp), 32'd1);
    check("stray_resp", 32'(resp), 32'(ram_val(4, 0)));
    @(negedge clk);
    check("wait_hold_state", 32'(dbg_state), 32'(S_WAIT));
    check("wait_hold_raddr", 32'(raddr), 32'd0);
    n_done = 0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    check("midrst_outputs", 32'({raddr, resp, send_resp, busy, dump_done}), 32'd0);
    check("midrst_no_done", 32'(n_done), 32'd0);

    // Invalid channel on the first cycle after reset release.
    rst_n  = 1'b1;
    start  = 1'b1;
    ch_sel = 3'd0;
    waddr  = LOG2'(77);
    snap   = n_send;
    @(negedge clk);
    start = 1'b0;
    check("nack_state", 32'(dbg_state), 32'(S_NACK));
    check("nack_resp", 32'(resp), 32'h0000_00EE);
    check("nack_send", 32'(send_resp), 32'd1);
    check("nack_busy", 32'(busy), 32'd1);
    check("nack_raddr", 32'(raddr), 32'd0);
    repeat (2) @(negedge clk);
    resp_sent = 1'b1;
    @(negedge clk);
    resp_sent = 1'b0;
    check("nack_done", 32'(dump_done), 32'd1);
    @(negedge clk);
    check("nack_idle", 32'(dbg_state), 32'(S_IDLE));
    check("nack_busy_clr", 32'(busy), 32'd0);
    check("nack_one_send", 32'(n_send - snap), 32'd1);

    // Channel 7 is also refused.
    start  = 1'b1;
    ch_sel = 3'd7;
    @(negedge clk);
    start = 1'b0;
    check("nack7_state", 32'(dbg_state), 32'(S_NACK));
    check("nack7_resp", 32'(resp), 32'h0000_00EE);
    resp_sent = 1'b1;
    @(negedge clk);
    resp_sent = 1'b0;
    check("nack7_done", 32'(dump_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dump_ctrl.md
DUMP_CTRL -- requirements
Module: dump_ctrl

Interface
REQ-001 Parameter: ENTRIES, 384, depth of each channel RAM queue (circular buffer).
REQ-002 Parameter: LOG2, 9, address width; 2^LOG2 >= ENTRIES.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: start  input  1  one-cycle dump request from command decoder.
REQ-006 Port: ch_sel  input  3  channel to dump; 1..5 valid, 0/6/7 invalid.
REQ-007 Port: waddr  input  LOG2  capture write pointer; location of the oldest sample.
REQ-008 Port: rdataCH1..rdataCH5  input  8 each  RAM read data; valid one cycle after raddr is presented.
REQ-009 Port: resp_sent  input  1  UART transmitter finished the current byte.
REQ-010 Port: raddr  output  LOG2  RAM read address, shared by all five channel RAMs.
REQ-011 Port: resp  output  8  byte to transmit.
REQ-012 Port: send_resp  output  1  one-cycle transmit strobe.
REQ-013 Port: busy  output  1  high from accepted start until the cycle dump_done is asserted, inclusive.
REQ-014 Port: dump_done  output  1  one-cycle completion pulse; the decoder uses it to drop cmd_rdy.

Function
REQ-015 States SHALL be IDLE, READ, SEND, WAIT and NACK, all registered.
REQ-016 In IDLE with start=1 and ch_sel in 1..5, the block SHALL latch ch_sel and waddr (start_addr), load raddr<=waddr, set busy, and go to READ.
REQ-017 In IDLE with start=1 and ch_sel invalid, the block SHALL load resp<=8'hEE, pulse send_resp, set busy, leave raddr unchanged, and go to NACK.
REQ-018 READ SHALL last exactly one cycle to cover RAM read latency, then go to SEND.
REQ-019 SEND SHALL register resp<=rdataCHn for the latched channel, assert send_resp for exactly that cycle, and go to WAIT.
REQ-020 In WAIT, the block SHALL hold raddr and resp stable until resp_sent=1.
REQ-021 On resp_sent in WAIT, if next(raddr)==start_addr the block SHALL pulse dump_done, clear busy and go to IDLE; otherwise it SHALL load raddr<=next(raddr) and go to READ.
REQ-022 next(a) SHALL be 0 when a==ENTRIES-1, else a+1; raddr SHALL never reach ENTRIES or above.
REQ-023 Each dump SHALL send exactly ENTRIES bytes, oldest first: start_addr..ENTRIES-1, then 0..start_addr-1.
REQ-024 On resp_sent in NACK, the block SHALL pulse dump_done, clear busy and go to IDLE.
REQ-025 In IDLE, READ and SEND, resp_sent SHALL be ignored.
REQ-026 start SHALL be ignored whenever busy=1.
REQ-027 Changes on waddr and ch_sel during a dump SHALL NOT affect that dump, because both values are latched.
REQ-028 Byte-to-byte spacing SHALL be 3 cycles (READ, SEND, WAIT) plus the UART wait time.

Reset
REQ-029 With rst_n=0 at a clock edge, state SHALL become IDLE and raddr, resp, send_resp, busy and dump_done SHALL all become 0; latched ch_sel and start_addr SHALL become 0.
REQ-030 Reset in the middle of a dump SHALL abort it with no dump_done pulse; a start is accepted on the first cycle after rst_n returns high.

Verification
REQ-031 Reset: hold rst_n=0 for 2 cycles during a dump -> all outputs 0 and state IDLE on the next edge; no dump_done pulse.
REQ-032 Normal dump: ch_sel=3, waddr=5, resp_sent returned 3 cycles after each send_resp -> 384 send_resp pulses; raddr runs 5..383, 0..4; each resp equals rdataCH3 at that address; one dump_done one cycle after the final resp_sent.
REQ-033 Wrap: waddr=383, ch_sel=1 -> raddr runs 383, 0, 1 ... 382; exactly 384 bytes; dump_done after the byte from address 382.
REQ-034 Invalid channel: ch_sel=0 with start -> resp=8'hEE, one send_resp, raddr unchanged; dump_done one cycle after resp_sent.
REQ-035 Ignored inputs: pulse start with ch_sel=5 and toggle waddr during a ch_sel=2 dump -> no restart; byte sequence and length unchanged.
REQ-036 Stray handshake: resp_sent held high in IDLE and in READ -> no state change and no extra send_resp.
